// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed common-anode 7-segment hex scanner
module seg7_scan #(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic        blank_lz,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        frame
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   snap;
    logic          lz;

    logic          tick;
    logic          frame_start;
    logic [1:0]    idx_next;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_dec;

    // Slot timing, nibble select for the upcoming slot, and leading-zero test
    always_comb begin
        tick        = (presc == PRESC_LAST);
        frame_start = tick && (idx == 2'd3);
        idx_next    = idx + 2'd1;
        nib         = 4'h0;
        blank       = 1'b0;
        case (idx_next)
            2'd0: nib = frame_start ? data[3:0] : snap[3:0];
            2'd1: begin
                nib   = snap[7:4];
                blank = lz && (snap[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = snap[11:8];
                blank = lz && (snap[15:8] == 8'h00);
            end
            default: begin
                nib   = snap[15:12];
                blank = lz && (snap[15:12] == 4'h0);
            end
        endcase
    end

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}
    always_comb begin
        seg_dec = 7'h7F;
        case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    // Prescaler: one digit slot every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Digit index and per-frame snapshot; capturing once per frame prevents tearing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx  <= 2'd3;
            snap <= 16'h0000;
            lz   <= 1'b0;
        end else if (tick) begin
            idx <= idx_next;
            if (frame_start) begin
                snap <= data;
                lz   <= blank_lz;
            end
        end
    end

    // Registered display outputs; frame is a single-cycle pulse on frame-start ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anodes   <= 4'b1111;
            segments <= 7'h7F;
            frame    <= 1'b0;
        end else begin
            frame <= frame_start;
            if (tick) begin
                anodes   <= ~(4'b0001 << idx_next);
                segments <= blank ? 7'h7F : seg_dec;
            end
        end
    end

endmodule
